waveform_renderer: RTL and testbench
====================================

WAVEFORM_RENDERER -- requirements
Module: waveform_renderer

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, visible columns.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, visible rows.
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 16, signed audio sample width.
REQ-004 SHALL have parameter SCALE_SHIFT, default 7, arithmetic right shift from sample to row offset.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_pulse  input  1  one-cycle start-of-frame strobe from the display timing generator.
REQ-008 SHALL have port sample_valid  input  1  upstream sample valid.
REQ-009 SHALL have port sample_data  input  SAMPLE_WIDTH  signed audio sample.
REQ-010 SHALL have port sample_ready  output  1  sample accept; a transfer occurs when sample_valid and sample_ready are both 1.
REQ-011 SHALL have port fb_wr_en  output  1  framebuffer write strobe.
REQ-012 SHALL have port fb_wr_addr  output  clog2(SCREEN_WIDTH*SCREEN_HEIGHT)  row-major pixel address, y*SCREEN_WIDTH+x.
REQ-013 SHALL have port fb_wr_data  output  1  pixel value; 1 = waveform, 0 = background.
REQ-014 SHALL have port fb_front  output  1  buffer index being displayed; writes always target buffer ~fb_front.
REQ-015 SHALL have port busy  output  1  high in every state except CAPTURE.

Function
REQ-016 SHALL implement states CAPTURE, RENDER and SWAP_WAIT, cycling CAPTURE -> RENDER -> SWAP_WAIT -> CAPTURE.
REQ-017 SHALL hold sample_ready high only in CAPTURE, and SHALL accept exactly SCREEN_WIDTH samples into columns 0..SCREEN_WIDTH-1 in arrival order.
REQ-018 SHALL not advance the column index on cycles without a transfer.
REQ-019 SHALL store, per column, the row y = (SCREEN_HEIGHT/2) - (sample_data >>> SCALE_SHIFT), computed signed with at least 2 guard bits and clamped to 0..SCREEN_HEIGHT-1.
REQ-020 SHALL drop sample_ready in the cycle after the SCREEN_WIDTH-th transfer and enter RENDER.
REQ-021 SHALL, in RENDER, issue exactly SCREEN_WIDTH*SCREEN_HEIGHT writes, one per cycle, in ascending fb_wr_addr order starting at 0, with no gaps.
REQ-022 SHALL assert the first write 2 cycles after entering RENDER, which allows 1 cycle for the column-store read.
REQ-023 SHALL drive fb_wr_data = 1 iff lo <= y <= hi, where lo/hi are the min/max of the stored rows of columns x-1 and x; at x = 0 both lo and hi equal the row of column 0.
REQ-024 SHALL enter SWAP_WAIT the cycle after the final write (address SCREEN_WIDTH*SCREEN_HEIGHT-1).
REQ-025 SHALL ignore frame_pulse in CAPTURE and RENDER.
REQ-026 SHALL, on the first frame_pulse seen in SWAP_WAIT, toggle fb_front on the next clock edge and return to CAPTURE.
REQ-027 SHALL keep fb_wr_en low outside RENDER, with fb_wr_addr and fb_wr_data don't-care whenever fb_wr_en is low.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-RENDER, immediately force state = CAPTURE, column index = 0, fb_wr_en = 0, fb_wr_addr = 0, fb_wr_data = 0, fb_front = 0, busy = 0 and sample_ready = 0.
REQ-029 SHALL raise sample_ready on the first clock edge after reset deassertion.
REQ-030 SHALL leave the column-store contents undefined after reset; contents are never read before a complete capture.

Structure
REQ-031 SHALL take SCREEN_WIDTH and SCREEN_HEIGHT from the shared display package, the same constants used by the display timing generator.
REQ-032 SHALL place the column store in sub-module column_store: SCREEN_WIDTH x clog2(SCREEN_HEIGHT) bits, 1 write port, 1 synchronous read port, 1-cycle read latency.

Verification
REQ-033 SHALL cover: 640 samples of 0 -> row 240 fully set (addresses 153600..154239), all other pixels 0, total of 640 ones.
REQ-034 SHALL cover: samples 32767 and -32768 -> stored rows 0 and 479 respectively (clamped from -15 and 496).
REQ-035 SHALL cover: columns 0..319 = 0 and columns 320..639 = -12800 -> column 320 set for rows 240..340 inclusive, total of 740 ones.
REQ-036 SHALL cover: random sample_valid gaps -> exactly 640 transfers accepted, and sample_ready low from the cycle after the 640th transfer until CAPTURE is re-entered.
REQ-037 SHALL cover: reset pulsed at write 100000 -> fb_wr_en low in the same cycle, fb_front = 0, and a following full capture renders correctly.
REQ-038 SHALL cover: frame_pulse during RENDER -> no effect; frame_pulse in SWAP_WAIT -> fb_front toggles exactly 1 cycle later and busy falls.

Source files
------------

// File: rtl/waveform_renderer_pkg.sv
// Shared display constants and renderer state encoding.
package waveform_renderer_pkg;

   localparam int DISP_WIDTH  = 640;
   localparam int DISP_HEIGHT = 480;

   typedef enum logic [1:0] {
      ST_CAPTURE   = 2'd0,
      ST_RENDER    = 2'd1,
      ST_SWAP_WAIT = 2'd2
   } render_state_t;

endpackage

// File: rtl/waveform_renderer_column_store.sv
// Per-column row memory: one write port, one registered read port.
module waveform_renderer_column_store #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 9,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/waveform_renderer.sv
// Captures one screen-width of audio samples, then rasterises the trace
// into the back framebuffer and swaps buffers on the next frame pulse.
module waveform_renderer
   import waveform_renderer_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DISP_WIDTH,
   parameter int SCREEN_HEIGHT = DISP_HEIGHT,
   parameter int SAMPLE_WIDTH  = 16,
   parameter int SCALE_SHIFT   = 7,
   localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_pulse,
   input  logic                           sample_valid,
   input  logic signed [SAMPLE_WIDTH-1:0] sample_data,
   output logic                           sample_ready,
   output logic                           fb_wr_en,
   output logic [ADDR_W-1:0]              fb_wr_addr,
   output logic                           fb_wr_data,
   output logic                           fb_front,
   output logic                           busy
);

   localparam int COL_W  = $clog2(SCREEN_WIDTH);
   localparam int ROW_W  = $clog2(SCREEN_HEIGHT);
   localparam int CALC_W = SAMPLE_WIDTH + ROW_W + 2;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SCREEN_WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SCREEN_HEIGHT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
   localparam logic signed [CALC_W-1:0] ROW_MID = CALC_W'(SCREEN_HEIGHT / 2);
   localparam logic signed [CALC_W-1:0] ROW_MAX = CALC_W'(SCREEN_HEIGHT - 1);

   function automatic logic [ROW_W-1:0] sample_to_row(input logic signed [SAMPLE_WIDTH-1:0] s);
      logic signed [SAMPLE_WIDTH-1:0] shifted;
      logic signed [CALC_W-1:0]       y;
      shifted = s >>> SCALE_SHIFT;
      y = ROW_MID - $signed({{(CALC_W-SAMPLE_WIDTH){shifted[SAMPLE_WIDTH-1]}}, shifted});
      if (y[CALC_W-1])    return '0;
      else if (y > ROW_MAX) return ROW_LAST;
      else                return y[ROW_W-1:0];
   endfunction

   render_state_t     state, state_next;
   logic [COL_W-1:0]  col;
   logic              xfer;
   logic [ROW_W-1:0]  row_rd;

   logic [COL_W-1:0]  x_p0;
   logic [ROW_W-1:0]  y_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic              scan_done, vld_p0;

   logic [COL_W-1:0]  x_p1;
   logic [ROW_W-1:0]  y_p1, row_prev_p1, lo_p1, hi_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic              vld_p1, pixel_p1;

   assign xfer = sample_valid && sample_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_CAPTURE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_CAPTURE:   if (xfer && col == COL_LAST) state_next = ST_RENDER;
         ST_RENDER:    if (fb_wr_en && fb_wr_addr == ADDR_LAST) state_next = ST_SWAP_WAIT;
         ST_SWAP_WAIT: if (frame_pulse) state_next = ST_CAPTURE;
         default:      state_next = ST_CAPTURE;
      endcase
   end

   always_comb begin
      busy   = (state != ST_CAPTURE);
      vld_p0 = (state == ST_RENDER) && !scan_done;
   end

   // Ready is registered so it rises on the first edge after reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_ready <= 1'b0;
         col          <= '0;
         fb_front     <= 1'b0;
      end else begin
         sample_ready <= (state_next == ST_CAPTURE);
         if (xfer) col <= (col == COL_LAST) ? '0 : col + 1'b1;
         if (state == ST_SWAP_WAIT && frame_pulse) fb_front <= ~fb_front;
      end
   end

   waveform_renderer_column_store #(
      .DEPTH  (SCREEN_WIDTH),
      .DATA_W (ROW_W),
      .ADDR_W (COL_W)
   ) column_store (
      .clk     (clk),
      .wr_en   (xfer),
      .wr_addr (col),
      .wr_data (sample_to_row(sample_data)),
      .rd_addr (x_p0),
      .rd_data (row_rd)
   );

   // p0: raster scan issues the column-store read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_p0 <= '0; y_p0 <= '0; addr_p0 <= '0; scan_done <= 1'b0;
      end else if (state != ST_RENDER) begin
         x_p0 <= '0; y_p0 <= '0; addr_p0 <= '0; scan_done <= 1'b0;
      end else if (vld_p0) begin
         addr_p0 <= addr_p0 + 1'b1;
         if (x_p0 == COL_LAST) begin
            x_p0 <= '0;
            if (y_p0 == ROW_LAST) scan_done <= 1'b1;
            else                  y_p0 <= y_p0 + 1'b1;
         end else begin
            x_p0 <= x_p0 + 1'b1;
         end
      end
   end

   // p1: stored row arrives; previous column's row is kept for the span
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      x_p1    <= x_p0;
      y_p1    <= y_p0;
      addr_p1 <= addr_p0;
      if (vld_p1) row_prev_p1 <= row_rd;
   end

   always_comb begin
      lo_p1 = row_rd;
      hi_p1 = row_rd;
      if (x_p1 != '0) begin
         if (row_prev_p1 < row_rd) lo_p1 = row_prev_p1;
         else                      hi_p1 = row_prev_p1;
      end
      pixel_p1 = (y_p1 >= lo_p1) && (y_p1 <= hi_p1);
   end

   // p2: framebuffer write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_wr_en   <= 1'b0;
         fb_wr_addr <= '0;
         fb_wr_data <= 1'b0;
      end else begin
         fb_wr_en   <= vld_p1;
         fb_wr_addr <= addr_p1;
         fb_wr_data <= pixel_p1;
      end
   end

endmodule

// File: tb/tb_waveform_renderer.sv
// Randomised bench for waveform_renderer on a reduced 64x48 screen with a
// behavioural trace model.
module tb_waveform_renderer;

   localparam int W  = 64;
   localparam int H  = 48;
   localparam int SW = 16;
   localparam int SH = 10;
   localparam int AW = $clog2(W * H);

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 frame_pulse;
   logic                 sample_valid;
   logic signed [SW-1:0] sample_data;
   logic                 sample_ready;
   logic                 fb_wr_en;
   logic [AW-1:0]        fb_wr_addr;
   logic                 fb_wr_data;
   logic                 fb_front;
   logic                 busy;

   int checks = 0;
   int passed = 0;
   int smp [W];
   bit img [W*H];
   int ones;
   bit exp_front = 1'b0;

   waveform_renderer #(
      .SCREEN_WIDTH  (W),
      .SCREEN_HEIGHT (H),
      .SAMPLE_WIDTH  (SW),
      .SCALE_SHIFT   (SH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_pulse  (frame_pulse),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .fb_wr_en     (fb_wr_en),
      .fb_wr_addr   (fb_wr_addr),
      .fb_wr_data   (fb_wr_data),
      .fb_front     (fb_front),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Row = centre minus floor(sample / 2^SH), clamped to the screen.
   function automatic int model_row(input int s);
      int d, q, y;
      d = 1 << SH;
      q = (s >= 0) ? s / d : -((-s + d - 1) / d);
      y = H / 2 - q;
      if (y < 0) y = 0;
      if (y > H - 1) y = H - 1;
      return y;
   endfunction

   function automatic bit model_pixel(input int addr);
      int x, y, r0, r1, lo, hi;
      x = addr % W;
      y = addr / W;
      r1 = model_row(smp[x]);
      r0 = (x == 0) ? r1 : model_row(smp[x-1]);
      lo = (r0 < r1) ? r0 : r1;
      hi = (r0 < r1) ? r1 : r0;
      return (y >= lo) && (y <= hi);
   endfunction

   task automatic capture(input string name, input bit gaps);
      int idx = 0;
      int cyc = 0;
      bit go, xf;
      while (idx < W && cyc < 20 * W) begin
         go = !(gaps && $urandom_range(0, 2) == 0);
         sample_valid = go;
         sample_data  = SW'(smp[idx]);
         xf = go && sample_ready;
         @(posedge clk); #1;
         cyc++;
         if (xf) idx++;
      end
      checks++;
      if (idx !== W) $display("FAIL %s transfers: got %0d expected %0d", name, idx, W);
      else passed++;
      checks++;
      if (sample_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL %s ready_drop: ready=%0b busy=%0b expected ready=0 busy=1", name, sample_ready, busy);
      else passed++;
   endtask

   task automatic render(input string name, input int pulse_at, input int reset_at);
      int n = 0, k = 0, first_k = -1, bad_addr = 0, bad_data = 0, extra = 0;
      bit pulsed = 1'b0;
      ones = 0;
      foreach (img[i]) img[i] = 1'b0;
      sample_valid = 1'b1;
      while (n < W * H && k < W * H + 50) begin
         @(posedge clk); #1;
         k++;
         frame_pulse = 1'b0;
         if (sample_ready) extra++;
         if (fb_wr_en && reset_at >= 0 && n == reset_at) begin
            reset = 1'b1;
            #1;
            checks++;
            if (fb_wr_en !== 1'b0 || fb_front !== 1'b0 || busy !== 1'b0 || sample_ready !== 1'b0)
               $display("FAIL %s reset_mid: en=%0b front=%0b busy=%0b ready=%0b expected all 0",
                        name, fb_wr_en, fb_front, busy, sample_ready);
            else passed++;
            sample_valid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            exp_front = 1'b0;
            return;
         end
         if (fb_wr_en) begin
            if (first_k < 0) first_k = k;
            if (int'(fb_wr_addr) != n) bad_addr++;
            if (fb_wr_data !== model_pixel(n)) bad_data++;
            img[n] = fb_wr_data;
            ones += int'(fb_wr_data);
            n++;
         end
         if (!pulsed && pulse_at >= 0 && n == pulse_at) begin
            frame_pulse = 1'b1;
            pulsed = 1'b1;
         end
      end
      sample_valid = 1'b0;
      checks++;
      if (first_k !== 2) $display("FAIL %s first_write_latency: got %0d expected 2", name, first_k);
      else passed++;
      checks++;
      if (n !== W * H) $display("FAIL %s write_count: got %0d expected %0d", name, n, W * H);
      else passed++;
      checks++;
      if (bad_addr !== 0) $display("FAIL %s addr_order: got %0d bad expected 0", name, bad_addr);
      else passed++;
      checks++;
      if (bad_data !== 0) $display("FAIL %s pixels: got %0d bad expected 0", name, bad_data);
      else passed++;
      checks++;
      if (extra !== 0) $display("FAIL %s extra_transfers: got %0d expected 0", name, extra);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (fb_wr_en !== 1'b0 || busy !== 1'b1)
         $display("FAIL %s swap_wait_entry: en=%0b busy=%0b expected en=0 busy=1", name, fb_wr_en, busy);
      else passed++;
   endtask

   task automatic swap(input string name);
      int bad = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (busy !== 1'b1 || sample_ready !== 1'b0 || fb_front !== exp_front) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL %s swap_hold: got %0d bad cycles expected 0", name, bad);
      else passed++;
      frame_pulse = 1'b1;
      @(posedge clk); #1;
      frame_pulse = 1'b0;
      exp_front = ~exp_front;
      checks++;
      if (fb_front !== exp_front || busy !== 1'b0)
         $display("FAIL %s swap: front=%0b busy=%0b expected front=%0b busy=0", name, fb_front, busy, exp_front);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (sample_ready !== 1'b1) $display("FAIL %s ready_return: got %0b expected 1", name, sample_ready);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1; frame_pulse = 1'b0; sample_valid = 1'b0; sample_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({fb_wr_en, busy, sample_ready, fb_front, fb_wr_data} !== 5'b0 || fb_wr_addr !== '0)
         $display("FAIL reset_state: en=%0b busy=%0b ready=%0b front=%0b data=%0b addr=%0d expected all 0",
                  fb_wr_en, busy, sample_ready, fb_front, fb_wr_data, fb_wr_addr);
      else passed++;
      reset = 1'b0;
      #2;
      checks++;
      if (sample_ready !== 1'b0) $display("FAIL reset_release_ready: got %0b expected 0", sample_ready);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (sample_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL reset_first_edge: ready=%0b busy=%0b expected ready=1 busy=0", sample_ready, busy);
      else passed++;
   endtask

   task automatic test_zero();
      int row_ones = 0;
      foreach (smp[i]) smp[i] = 0;
      capture("zero", 1'b0);
      render("zero", -1, -1);
      for (int x = 0; x < W; x++) row_ones += int'(img[(H/2)*W + x]);
      checks++;
      if (ones !== W) $display("FAIL zero_total: got %0d expected %0d", ones, W);
      else passed++;
      checks++;
      if (row_ones !== W) $display("FAIL zero_centre_row: got %0d expected %0d", row_ones, W);
      else passed++;
      swap("zero");
   endtask

   task automatic test_clamp();
      foreach (smp[i]) smp[i] = 32767;
      smp[W-1] = -32768;
      capture("clamp", 1'b0);
      render("clamp", -1, -1);
      checks++;
      if (img[5] !== 1'b1 || img[(H-1)*W + W-1] !== 1'b1 || img[(H-1)*W + 5] !== 1'b0)
         $display("FAIL clamp_pixels: top=%0b bottom_last=%0b bottom_5=%0b expected 1 1 0",
                  img[5], img[(H-1)*W + W-1], img[(H-1)*W + 5]);
      else passed++;
      checks++;
      if (ones !== (W - 1) + H) $display("FAIL clamp_total: got %0d expected %0d", ones, (W - 1) + H);
      else passed++;
      swap("clamp");
   endtask

   task automatic test_step();
      int col_ones = 0;
      bit front_before;
      foreach (smp[i]) smp[i] = (i < W / 2) ? 0 : -10240;
      front_before = fb_front;
      capture("step", 1'b0);
      render("step", 1000, -1);
      for (int y = 0; y < H; y++) col_ones += int'(img[y*W + W/2]);
      // -10240 >>> 10 = -10: step column spans rows 24..34
      checks++;
      if (col_ones !== 11) $display("FAIL step_column: got %0d expected 11", col_ones);
      else passed++;
      checks++;
      if (ones !== W + 10) $display("FAIL step_total: got %0d expected %0d", ones, W + 10);
      else passed++;
      checks++;
      if (fb_front !== front_before)
         $display("FAIL step_pulse_in_render: front=%0b expected %0b", fb_front, front_before);
      else passed++;
      swap("step");
   endtask

   task automatic test_reset_mid_render();
      foreach (smp[i]) smp[i] = int'($urandom_range(0, 49152)) - 24576;
      capture("midreset", 1'b0);
      render("midreset", -1, 1000);
   endtask

   task automatic test_gaps();
      foreach (smp[i]) smp[i] = int'($urandom_range(0, 65535)) - 32768;
      for (int i = 0; i < 8; i++) smp[$urandom_range(0, W - 1)] = int'($urandom_range(0, 8192)) - 4096;
      capture("gaps", 1'b1);
      render("gaps", -1, -1);
      swap("gaps");
   endtask

   initial begin
      test_reset();
      test_zero();
      test_clamp();
      test_step();
      test_reset_mid_render();
      test_gaps();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
